// File: rtl/spectro_mem_pkg.sv
// Shared spectrogram RAM definitions: width derivation, ring-slot to bank mapping and the
// write-side state encoding. Imported by both the frame writer and the display address mapper.
package spectro_mem_pkg;

  localparam int unsigned NoBanks      = 2;
  localparam int unsigned RamAddrWidth = 12;
  localparam int unsigned NoFfts       = 50;
  localparam int unsigned FftSize      = 256;
  localparam int unsigned DataW        = 4;

  function automatic int unsigned idx_width(input int unsigned no_ffts);
    return $clog2(no_ffts);
  endfunction

  function automatic int unsigned bin_width(input int unsigned fft_size);
    return $clog2(fft_size);
  endfunction

  localparam int unsigned IdxW = idx_width(NoFfts);

  typedef enum logic [1:0] {
    StWrite,
    StSkip,
    StCommit,
    StResync
  } wr_state_t;

  // The MSB of the ring slot picks the bank; the remaining bits form the slot offset in it.
  function automatic logic [NoBanks-1:0] bank_sel(input logic [IdxW-1:0] idx);
    return idx[IdxW-1] ? NoBanks'(2) : NoBanks'(1);
  endfunction

endpackage

// File: rtl/ring_idx_counter.sv
// Modulo-Depth ring index with enable; next_o exposes the value loaded on the next enable.
module ring_idx_counter #(
  parameter int unsigned Depth = 50,
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [Width-1:0] idx_o,
  output logic [Width-1:0] next_o
);

  logic [Width-1:0] idx_q;

  always_comb begin
    next_o = (idx_q == Width'(Depth - 1)) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (en_i) begin
      idx_q <= next_o;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/fft_frame_writer.sv
// Writes the lower half of each streamed FFT frame into its ring slot and commits it in vblank.
// Optional FFT_FRAME_WRITER_DROP_EN: accept and discard frames arriving while a commit is pending.
module fft_frame_writer
  import spectro_mem_pkg::*;
#(
  parameter int unsigned NO_BANKS       = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 12,
  parameter int unsigned NO_FFTS        = 50,
  parameter int unsigned FFT_SIZE       = 256,
  parameter int unsigned DATA_W         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_last,
  input  logic                       vblank,
  output logic                       wr_en,
  output logic [NO_BANKS-1:0]        wr_bank_select,
  output logic [RAM_ADDR_WIDTH-1:0]  wr_address,
  output logic [DATA_W-1:0]          wr_data,
  output logic [$clog2(NO_FFTS)-1:0] oldest_fft_idx,
  output logic                       frame_err
`ifdef FFT_FRAME_WRITER_DROP_EN
  ,
  output logic [15:0]                dropped_frames
`endif
);

  localparam int unsigned IDX_W = idx_width(NO_FFTS);
  localparam int unsigned BIN_W = bin_width(FFT_SIZE);
  localparam logic [BIN_W-1:0] HalfBin = BIN_W'(FFT_SIZE / 2);
  localparam logic [BIN_W-1:0] LastBin = BIN_W'(FFT_SIZE - 1);

  wr_state_t state_q, state_d;
  logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d, bin_inc;
  logic [IDX_W-1:0] write_idx, write_idx_next, oldest_q;
  logic             last_bin, issue, err, commit;

  logic                      wr_en_q, frame_err_q;
  logic [NO_BANKS-1:0]       wr_bank_q;
  logic [RAM_ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_W-1:0]         wr_data_q;

`ifdef FFT_FRAME_WRITER_DROP_EN
  logic [15:0] dropped_q, dropped_d;
`endif

  ring_idx_counter #(
    .Depth (NO_FFTS),
    .Width (IDX_W)
  ) u_write_idx (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (commit),
    .idx_o  (write_idx),
    .next_o (write_idx_next)
  );

  assign bin_inc  = bin_cnt_q + 1'b1;
  assign last_bin = (bin_cnt_q == LastBin);

  // s_valid is used directly as the accept term: s_ready is constant within each state branch.
  always_comb begin
    state_d   = state_q;
    bin_cnt_d = bin_cnt_q;
    s_ready   = 1'b0;
    issue     = 1'b0;
    err       = 1'b0;
    commit    = 1'b0;
`ifdef FFT_FRAME_WRITER_DROP_EN
    dropped_d = dropped_q;
`endif
    unique case (state_q)
      StWrite, StSkip: begin
        s_ready = 1'b1;
        if (s_valid) begin
          issue = (state_q == StWrite) && (bin_cnt_q < HalfBin);
          err   = (s_last != last_bin);
          if (last_bin) begin
            bin_cnt_d = '0;
            state_d   = s_last ? StCommit : StResync;
          end else if (s_last) begin
            bin_cnt_d = '0;
            state_d   = StWrite;
          end else begin
            bin_cnt_d = bin_inc;
            state_d   = (bin_inc >= HalfBin) ? StSkip : StWrite;
          end
        end
      end
      StCommit: begin
`ifdef FFT_FRAME_WRITER_DROP_EN
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_last) begin
            bin_cnt_d = '0;
            if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
          end else begin
            bin_cnt_d = bin_inc;
          end
        end
`endif
        if (vblank) begin
          commit    = 1'b1;
          bin_cnt_d = '0;
          state_d   = StWrite;
`ifdef FFT_FRAME_WRITER_DROP_EN
          // A frame caught mid-drop is discarded to its end before writing resumes.
          if (s_valid ? !s_last : (bin_cnt_q != '0)) state_d = StResync;
`endif
        end
      end
      StResync: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          bin_cnt_d = '0;
          state_d   = StWrite;
        end
      end
      default: state_d = StWrite;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StWrite;
      bin_cnt_q   <= '0;
      oldest_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      wr_en_q     <= issue;
      frame_err_q <= err;
      if (commit) oldest_q <= write_idx_next;
      if (issue) begin
        wr_bank_q <= NO_BANKS'(bank_sel(IdxW'(write_idx)));
        wr_addr_q <= RAM_ADDR_WIDTH'({write_idx[IDX_W-2:0], bin_cnt_q[BIN_W-2:0]});
        wr_data_q <= s_data;
      end
    end
  end

`ifdef FFT_FRAME_WRITER_DROP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dropped_q <= '0;
    end else begin
      dropped_q <= dropped_d;
    end
  end

  assign dropped_frames = dropped_q;
`endif

  assign wr_en          = wr_en_q;
  assign wr_bank_select = wr_bank_q;
  assign wr_address     = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign oldest_fft_idx = oldest_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_fft_frame_writer.sv
// Randomized frame stimulus checked against a slot/bin arithmetic model of the spectrogram writer.
module tb_fft_frame_writer;

  localparam int NF   = 50;
  localparam int HALF = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        vblank = 1'b0;
  logic [3:0]  s_data = '0;
  logic        s_ready;
  logic        wr_en;
  logic [1:0]  wr_bank_select;
  logic [11:0] wr_address;
  logic [3:0]  wr_data;
  logic [5:0]  oldest_fft_idx;
  logic        frame_err;
`ifdef FFT_FRAME_WRITER_DROP_EN
  logic [15:0] dropped_frames;
`endif

  fft_frame_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .vblank         (vblank),
    .wr_en          (wr_en),
    .wr_bank_select (wr_bank_select),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .oldest_fft_idx (oldest_fft_idx),
    .frame_err      (frame_err)
`ifdef FFT_FRAME_WRITER_DROP_EN
    ,
    .dropped_frames (dropped_frames)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int model_slot = 0;
  int model_oldest = 0;
  int unsigned obs_q[$];
  int unsigned exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  // Observed RAM writes packed as {bank, address, data}.
  always @(negedge clk) begin
    if (wr_en) obs_q.push_back(32'({wr_bank_select, wr_address, wr_data}));
    if (frame_err) err_pulses++;
  end

  function automatic int unsigned exp_write(input int slot, input int bin, input int data);
    int bank;
    int addr;
    bank = (slot >= 32) ? 2 : 1;
    addr = (slot % 32) * HALF + bin;
    return (bank << 16) | (addr << 4) | data;
  endfunction

  task automatic send_beat(input logic [3:0] d, input bit last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check_eq("s_ready_wait", 32'(s_ready), 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int len, input int last_pos, input bit expect_wr,
                            input bit vb_before_last);
    for (int i = 0; i < len; i++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      if (expect_wr && i < HALF) exp_q.push_back(exp_write(model_slot, i, int'(d)));
      if (vb_before_last && i == len - 1) vblank = 1'b1;
      send_beat(d, i == last_pos);
    end
  endtask

  task automatic check_writes(input string tag);
    int n;
    repeat (2) @(negedge clk);
    check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic clean_frame_commit(input bit vb_early);
    int old_idx;
    old_idx = model_oldest;
    send_frame(256, 255, 1'b1, vb_early);
    check_eq("oldest_hold", 32'(oldest_fft_idx), 32'(old_idx));
`ifndef FFT_FRAME_WRITER_DROP_EN
    check_eq("s_ready_commit", 32'(s_ready), 0);
`endif
    if (!vb_early) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_eq("oldest_wait", 32'(oldest_fft_idx), 32'(old_idx));
      vblank = 1'b1;
    end
    @(negedge clk);
    vblank = 1'b0;
    model_slot   = (model_slot + 1) % NF;
    model_oldest = model_slot;
    check_eq("oldest_commit", 32'(oldest_fft_idx), 32'(model_oldest));
    check_eq("s_ready_after", 32'(s_ready), 1);
    check_writes("frame_wr");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    check_eq("rst_wr_en", 32'(wr_en), 0);
    check_eq("rst_bank", 32'(wr_bank_select), 0);
    check_eq("rst_addr", 32'(wr_address), 0);
    check_eq("rst_data", 32'(wr_data), 0);
    check_eq("rst_oldest", 32'(oldest_fft_idx), 0);
    check_eq("rst_frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 1);

    // First frame waits in commit for a while, then 49 more frames wrap the ring.
    clean_frame_commit(1'b0);
    for (int f = 1; f < NF; f++) clean_frame_commit(1'($urandom_range(0, 1)));
    check_eq("wrap_oldest", 32'(oldest_fft_idx), 0);
    check_eq("clean_no_err", 32'(err_pulses), 0);

    // Early s_last on beat 100.
    e0 = err_pulses;
    send_frame(101, 100, 1'b1, 1'b0);
    check_writes("early_wr");
    check_eq("early_err", 32'(err_pulses), 32'(e0 + 1));
    check_eq("early_oldest", 32'(oldest_fft_idx), 32'(model_oldest));
    check_eq("early_ready", 32'(s_ready), 1);
    clean_frame_commit(1'b0);

    // Missing s_last on beat 255, 10 extra beats end the frame.
    e0 = err_pulses;
    send_frame(266, 265, 1'b1, 1'b0);
    check_writes("resync_wr");
    check_eq("resync_err", 32'(err_pulses), 32'(e0 + 1));
    check_eq("resync_oldest", 32'(oldest_fft_idx), 32'(model_oldest));
    check_eq("resync_ready", 32'(s_ready), 1);
    clean_frame_commit(1'b1);

`ifdef FFT_FRAME_WRITER_DROP_EN
    send_frame(256, 255, 1'b1, 1'b0);
    check_writes("pre_drop_wr");
    check_eq("drop_ready", 32'(s_ready), 1);
    send_frame(256, 255, 1'b0, 1'b0);
    check_writes("drop_wr");
    check_eq("dropped_frames", 32'(dropped_frames), 1);
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    model_slot   = (model_slot + 1) % NF;
    model_oldest = model_slot;
    check_eq("drop_oldest", 32'(oldest_fft_idx), 32'(model_oldest));
    clean_frame_commit(1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
